alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that implements 16x16 unsigned multiply and 16/16 unsigned divide.
- Drives the shared 16-bit ALU one iteration per cycle: shift-add for multiply, restoring subtract for divide.
- Sits beside the execute stage. The ALU operand mux selects this block's ALU drive while busy is high.
- Results are registered and held until the next accepted start.

Parameters:
- WIDTH, 16: operand width; must match the ALU's OPERAND_WIDTH.
- CNT_W, 4: iteration counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- op_div  input  1  0 = multiply, 1 = divide; sampled with start.
- opa  input  WIDTH  multiplicand or dividend; sampled with start.
- opb  input  WIDTH  multiplier or divisor; sampled with start.
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- div_zero  output  1  set with done when divisor = 0; held until the next accepted start.
- res_hi  output  WIDTH  multiply: product[31:16]; divide: remainder.
- res_lo  output  WIDTH  multiply: product[15:0]; divide: quotient.
- alu_a  output  WIDTH  ALU InA drive.
- alu_b  output  WIDTH  ALU InB drive.
- alu_cin  output  1  ALU Cin drive.
- alu_invb  output  1  ALU invB drive (invA is tied 0 externally).
- alu_oper  output  4  ALU Oper drive; constant 4'd4 (add).
- alu_out  input  WIDTH  ALU Out; combinational return in the same cycle.
- alu_cout  input  1  ALU Cout; combinational return in the same cycle.

Behaviour:
Reset:
- rst_n low forces state = IDLE and clears busy, done, div_zero, res_hi, res_lo, the counter and all operand registers to 0.
- Reset takes effect immediately, including mid-RUN. The in-flight operation is discarded and no done is produced.

State machine:
- IDLE or DONE with start=1 and op_div=1 and opb=0 → DONE next cycle. Sets div_zero=1, res_lo=16'hFFFF, res_hi=opa. No RUN cycles.
- IDLE or DONE with start=1 otherwise → RUN. Loads mcand/divisor=opb, lo=opa (multiply: lo=opb and mcand=opa), hi=0, cnt=15, div_zero=0.
- RUN: one iteration per cycle. When cnt=0 the iteration completes and the next state is DONE; otherwise cnt decrements.
- DONE: done=1 for exactly this cycle, then IDLE unless a new start is accepted.
- start while in RUN is ignored: no effect on state, operands or results.
- Latency: start accepted at edge N → busy high for the cycles after edges N..N+15 → done high after edge N+16 (17 cycles start-to-done). Divide-by-zero: done after edge N+1.

Multiply iteration (RUN, op_div=0):
- ALU drive: alu_a=hi, alu_b=mcand, alu_cin=0, alu_invb=0.
- If lo[0]=1: {c,s} = {alu_cout, alu_out}; else {c,s} = {0, hi}.
- Update: hi <= {c, s[15:1]}, lo <= {s[0], lo[15:1]}.

Divide iteration (RUN, op_div=1, restoring):
- Shifted partial remainder: sh = {hi[14:0], lo[15]}, top bit t = hi[15].
- ALU drive: alu_a=sh, alu_b=divisor, alu_invb=1, alu_cin=1 (computes sh - divisor).
- If t | alu_cout: hi <= alu_out, lo <= {lo[14:0], 1}.
- Else: hi <= sh, lo <= {lo[14:0], 0}.

Output mapping and idle drive:
- res_hi/res_lo are the hi/lo registers. They update every RUN cycle (intermediate values) and are valid and stable from done until the next accepted start.
- Outside RUN: alu_a=0, alu_b=0, alu_cin=0, alu_invb=0. alu_oper=4'd4 always.

Test Plan:
- Multiply: op_div=0, opa=3, opb=5 → done exactly 17 cycles after start; res_hi=0x0000, res_lo=0x000F; busy high for 16 cycles.
- Multiply worst case: opa=0xFFFF, opb=0xFFFF → res_hi=0xFFFE, res_lo=0x0001; then opa=0x8000, opb=0x0002 → res_hi=0x0001, res_lo=0x0000.
- Divide: opa=100, opb=7 → res_lo=14, res_hi=2, div_zero=0. Also opa=0xFFFF, opb=0x8001 → res_lo=1, res_hi=0x7FFE.
- Divide by zero: opa=0x1234, opb=0 → done the cycle after start; div_zero=1, res_lo=0xFFFF, res_hi=0x1234; busy never asserts.
- start pulsed with new operands at RUN cycle 5 → ignored; the original result is produced with original timing. start in the done cycle → new op accepted, busy the next cycle.
- rst_n low at RUN cycle 8 → all outputs 0 immediately, no done. After release, a fresh 3*5 gives 15.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Sequencer for 16x16 unsigned multiply and 16/16 unsigned divide on a shared adder ALU.
// Each RUN cycle does one shift-add (multiply) or one restoring subtract (divide).
//   state | meaning
//   IDLE  | waiting for start, results held
//   RUN   | iterating, ALU driven by this block
//   DONE  | one-cycle done pulse, results valid
module alu_muldiv_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic             alu_invb,
  output logic [3:0]       alu_oper,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic             op_div_q, op_div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sum;
  logic             carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_div_q   <= 1'b0;
      cnt_q      <= '0;
      mcand_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_div_q   <= op_div_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_div_d   = op_div_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    alu_invb   = 1'b0;
    sh         = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    sum        = hi_q;
    carry      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_div_d = op_div;
          if (op_div && (opb == '0)) begin
            // Divide by zero short-circuits straight to DONE with all-ones quotient.
            state_d    = DONE;
            div_zero_d = 1'b1;
            hi_d       = opa;
            lo_d       = '1;
          end else begin
            state_d    = RUN;
            div_zero_d = 1'b0;
            hi_d       = '0;
            cnt_d      = CNT_W'(WIDTH - 1);
            mcand_d    = op_div ? opb : opa;
            lo_d       = op_div ? opa : opb;
          end
        end
      end

      RUN: begin
        if (op_div_q) begin
          alu_a    = sh;
          alu_b    = mcand_q;
          alu_invb = 1'b1;
          alu_cin  = 1'b1;
          // hi_q[15] set means the shifted remainder is 17 bits wide and always >= divisor.
          if (hi_q[WIDTH-1] | alu_cout) begin
            hi_d = alu_out;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = sh;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          alu_a = hi_q;
          alu_b = mcand_q;
          if (lo_q[0]) begin
            sum   = alu_out;
            carry = alu_cout;
          end
          hi_d = {carry, sum[WIDTH-1:1]};
          lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign div_zero = div_zero_q;
  assign res_hi   = hi_q;
  assign res_lo   = lo_q;
  assign alu_oper = 4'd4;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq with a behavioural adder ALU and a result scoreboard.
module tb_alu_muldiv_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_div = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] res_hi, res_lo, alu_a, alu_b, alu_out;
  logic         alu_cin, alu_invb, alu_cout;
  logic [3:0]   alu_oper;

  alu_muldiv_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .div_zero(div_zero), .res_hi(res_hi), .res_lo(res_lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_invb(alu_invb),
    .alu_oper(alu_oper), .alu_out(alu_out), .alu_cout(alu_cout)
  );

  // Adder ALU with optional B inversion
  logic [W:0] alu_sum;
  assign alu_sum  = {1'b0, alu_a} + {1'b0, (alu_invb ? ~alu_b : alu_b)} + {{W{1'b0}}, alu_cin};
  assign alu_out  = alu_sum[W-1:0];
  assign alu_cout = alu_sum[W];

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  typedef struct {
    logic         od;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic         dz;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t model(input logic od, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    if (!od) begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
      e.dz = 1'b0;
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
    end else begin
      e.hi = a % b;
      e.lo = a / b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drives a start in the current cycle; returns at the sample point after the accepting edge.
  task automatic issue(input logic od, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    @(negedge clk);
    op_div = od;
    opa    = a;
    opb    = b;
    start  = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic od, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int exp_lat, input int poke);
    int   lat;
    int   busy_n;
    exp_t e;
    lat    = 1;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (lat == 1 && busy) begin
        if (od) check({tag, " alu_drv"}, {alu_a, alu_b, alu_cin, alu_invb, alu_oper},
                      {{{(W-1){1'b0}}, a[W-1]}, b, 1'b1, 1'b1, 4'd4});
        else    check({tag, " alu_drv"}, {alu_a, alu_b, alu_cin, alu_invb, alu_oper},
                      {{W{1'b0}}, a, 1'b0, 1'b0, 4'd4});
      end
      if (poke != 0 && lat == poke) begin
        @(negedge clk);
        start  = 1'b1;
        op_div = ~od;
        opa    = 16'h5555;
        opb    = 16'h0003;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_n, exp_lat - 1);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard_nonempty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({tag, " res_hi"}, res_hi, e.hi);
      check({tag, " res_lo"}, res_lo, e.lo);
      check({tag, " div_zero"}, div_zero, e.dz);
    end
  endtask

  task automatic check_hold(input string tag, input exp_t e);
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, {done, busy}, 2'b00);
    check({tag, " held"}, {res_hi, res_lo, div_zero}, {e.hi, e.lo, e.dz});
  endtask

  task automatic add_vec(input logic od, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic dz);
    vec_t v;
    v.od = od; v.a = a; v.b = b; v.eh = eh; v.el = el; v.dz = dz;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    int   done_seen;

    add_vec(1'b0, 16'd3,    16'd5,    16'h0000, 16'h000F, 1'b0);
    add_vec(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
    add_vec(1'b0, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 1'b0);
    add_vec(1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0);
    add_vec(1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0);
    add_vec(1'b1, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0);
    add_vec(1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0);
    add_vec(1'b1, 16'd1000, 16'd10,   16'd0,    16'd100,  1'b0);
    add_vec(1'b1, 16'd5,    16'd9,    16'd5,    16'd0,    1'b0);
    add_vec(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);
    add_vec(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {busy, done, div_zero, res_hi, res_lo},
          {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000});
    check("reset alu_drive", {alu_a, alu_b, alu_cin, alu_invb, alu_oper},
          {16'h0000, 16'h0000, 1'b0, 1'b0, 4'd4});
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      e.hi = vecs[i].eh;
      e.lo = vecs[i].el;
      e.dz = vecs[i].dz;
      issue(vecs[i].od, vecs[i].a, vecs[i].b, e);
      wait_done($sformatf("vec%0d", i), vecs[i].od, vecs[i].a, vecs[i].b,
                vecs[i].dz ? 1 : 17, 0);
      check_hold($sformatf("vec%0d", i), e);
    end

    for (int i = 0; i < 6; i++) begin
      logic         od;
      logic [W-1:0] a, b;
      od = i[0];
      a  = W'($urandom);
      b  = W'($urandom);
      if (od && b == '0) b = 16'h0001;
      e  = model(od, a, b);
      issue(od, a, b, e);
      wait_done($sformatf("rnd%0d", i), od, a, b, 17, 0);
    end

    // start during RUN must be ignored
    e = model(1'b0, 16'd3, 16'd5);
    issue(1'b0, 16'd3, 16'd5, e);
    wait_done("ignore_start", 1'b0, 16'd3, 16'd5, 17, 5);
    check_hold("ignore_start", e);

    // start in the DONE cycle is accepted immediately, including from a divide-by-zero DONE
    e = model(1'b1, 16'h00AA, 16'h0000);
    issue(1'b1, 16'h00AA, 16'h0000, e);
    wait_done("dz_b2b", 1'b1, 16'h00AA, 16'h0000, 1, 0);
    e = model(1'b0, 16'd3, 16'd5);
    issue(1'b0, 16'd3, 16'd5, e);
    check("dz_b2b busy_next", {busy, div_zero}, 2'b10);
    wait_done("b2b_first", 1'b0, 16'd3, 16'd5, 17, 0);
    e = model(1'b1, 16'd100, 16'd7);
    issue(1'b1, 16'd100, 16'd7, e);
    check("b2b busy_next", {busy, done}, 2'b10);
    wait_done("b2b_second", 1'b1, 16'd100, 16'd7, 17, 0);

    // Asynchronous reset mid-RUN discards the operation
    e = model(1'b0, 16'd3, 16'd5);
    issue(1'b0, 16'd3, 16'd5, e);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset outputs", {busy, done, div_zero, res_hi, res_lo},
          {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000});
    check("async_reset alu", {alu_a, alu_b, alu_cin, alu_invb}, {16'h0000, 16'h0000, 1'b0, 1'b0});
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("no_done_after_reset", done_seen, 0);
    e = model(1'b0, 16'd3, 16'd5);
    issue(1'b0, 16'd3, 16'd5, e);
    wait_done("post_reset", 1'b0, 16'd3, 16'd5, 17, 0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
